// File: rtl/simple_alu_pipe.sv
// Pipelined simple-ALU lane: combinational ALU in stage 1, STAGES-deep valid/ready pipe with flush.
// Optional signed-overflow trap when SIMPLE_ALU_OVF_TRAP_EN is defined.
`ifndef SIMPLE_ALU_PIPE_DEFS
`define SIMPLE_ALU_PIPE_DEFS
`define SIZE_OPCODE_I   6
`define EXECUTION_FLAGS 6
`define ALU_NOP   6'd0
`define ALU_ADD   6'd1
`define ALU_ADDI  6'd2
`define ALU_ADDU  6'd3
`define ALU_ADDIU 6'd4
`define ALU_SUB   6'd5
`define ALU_SUBU  6'd6
`define ALU_MFHI  6'd7
`define ALU_MTHI  6'd8
`define ALU_MFLO  6'd9
`define ALU_MTLO  6'd10
`define ALU_AND_  6'd11
`define ALU_ANDI  6'd12
`define ALU_OR    6'd13
`define ALU_ORI   6'd14
`define ALU_XOR   6'd15
`define ALU_XORI  6'd16
`define ALU_NOR   6'd17
`define ALU_SLL   6'd18
`define ALU_SLLV  6'd19
`define ALU_SRL   6'd20
`define ALU_SRLV  6'd21
`define ALU_SRA   6'd22
`define ALU_SRAV  6'd23
`define ALU_SLT   6'd24
`define ALU_SLTI  6'd25
`define ALU_SLTU  6'd26
`define ALU_SLTIU 6'd27
`define ALU_LUI   6'd28
`endif

module simple_alu_pipe #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int STAGES = 2,
  parameter int TAG_W  = 7
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  input  logic [`SIZE_OPCODE_I-1:0]     opcode_i,
  input  logic [DATA_W-1:0]             data1_i,
  input  logic [DATA_W-1:0]             data2_i,
  input  logic [IMM_W-1:0]              immd_i,
  input  logic [TAG_W-1:0]              tag_i,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [DATA_W-1:0]             result_o,
  output logic [`EXECUTION_FLAGS-1:0]   flags_o,
  output logic [TAG_W-1:0]              tag_o
);

  localparam int SHW = $clog2(DATA_W);
  localparam int MSB = DATA_W - 1;

  logic [DATA_W-1:0] imm_sext;
  logic [DATA_W-1:0] imm_zext;
  logic [SHW-1:0]    sh_imm;
  logic [SHW-1:0]    sh_var;
  logic [DATA_W:0]   add_sum;
  logic [DATA_W:0]   addi_sum;
  logic [DATA_W:0]   sub_diff;

  logic [DATA_W-1:0]           alu_res;
  logic                        alu_known;
  logic                        alu_nop;
  logic                        alu_carry;
  logic                        alu_ovf;
  logic [`EXECUTION_FLAGS-1:0] alu_flags;

  assign imm_sext = DATA_W'($signed(immd_i));
  assign imm_zext = DATA_W'(immd_i);
  assign sh_imm   = imm_zext[SHW-1:0];
  assign sh_var   = data1_i[SHW-1:0];
  assign add_sum  = {1'b0, data1_i} + {1'b0, data2_i};
  assign addi_sum = {1'b0, data1_i} + {1'b0, imm_sext};
  assign sub_diff = {1'b0, data1_i} - {1'b0, data2_i};

  // HI/LO moves pass data1 through; the HI/LO registers live outside this lane.
  always_comb begin
    alu_res   = '0;
    alu_known = 1'b1;
    alu_nop   = 1'b0;
    alu_carry = 1'b0;
    case (opcode_i)
      `ALU_ADD:   begin alu_res = add_sum[MSB:0];  alu_carry = add_sum[DATA_W];  end
      `ALU_ADDI:  begin alu_res = addi_sum[MSB:0]; alu_carry = addi_sum[DATA_W]; end
      `ALU_ADDU:  alu_res = add_sum[MSB:0];
      `ALU_ADDIU: alu_res = addi_sum[MSB:0];
      `ALU_SUB:   begin alu_res = sub_diff[MSB:0]; alu_carry = sub_diff[DATA_W]; end
      `ALU_SUBU:  alu_res = sub_diff[MSB:0];
      `ALU_MFHI, `ALU_MTHI, `ALU_MFLO, `ALU_MTLO: alu_res = data1_i;
      `ALU_AND_:  alu_res = data1_i & data2_i;
      `ALU_ANDI:  alu_res = data1_i & imm_zext;
      `ALU_OR:    alu_res = data1_i | data2_i;
      `ALU_ORI:   alu_res = data1_i | imm_zext;
      `ALU_XOR:   alu_res = data1_i ^ data2_i;
      `ALU_XORI:  alu_res = data1_i ^ imm_zext;
      `ALU_NOR:   alu_res = ~(data1_i | data2_i);
      `ALU_SLL:   alu_res = data1_i << sh_imm;
      `ALU_SLLV:  alu_res = data2_i << sh_var;
      `ALU_SRL:   alu_res = data1_i >> sh_imm;
      `ALU_SRLV:  alu_res = data2_i >> sh_var;
      `ALU_SRA:   alu_res = $signed(data1_i) >>> sh_imm;
      `ALU_SRAV:  alu_res = $signed(data2_i) >>> sh_var;
      `ALU_SLT:   alu_res = DATA_W'($signed(data1_i) < $signed(data2_i));
      `ALU_SLTI:  alu_res = DATA_W'($signed(data1_i) < $signed(imm_sext));
      `ALU_SLTU:  alu_res = DATA_W'(data1_i < data2_i);
      `ALU_SLTIU: alu_res = DATA_W'(data1_i < imm_zext);
      `ALU_LUI:   alu_res = imm_zext << (DATA_W - IMM_W);
      `ALU_NOP:   alu_nop = 1'b1;
      default:    alu_known = 1'b0;
    endcase
  end

`ifdef SIMPLE_ALU_OVF_TRAP_EN
  always_comb begin
    alu_ovf = 1'b0;
    case (opcode_i)
      `ALU_ADD:  alu_ovf = (data1_i[MSB] == data2_i[MSB])  && (add_sum[MSB]  != data1_i[MSB]);
      `ALU_ADDI: alu_ovf = (data1_i[MSB] == imm_sext[MSB]) && (addi_sum[MSB] != data1_i[MSB]);
      `ALU_SUB:  alu_ovf = (data1_i[MSB] != data2_i[MSB])  && (sub_diff[MSB] != data1_i[MSB]);
      default:   alu_ovf = 1'b0;
    endcase
  end
`else
  assign alu_ovf = 1'b0;
`endif

  // Overflow trap wins over the register write so a trapping op never commits.
  assign alu_flags = alu_known ? {alu_ovf, ~alu_nop & ~alu_ovf, 1'b0, 1'b1, alu_carry, 1'b0}
                               : '0;

  logic [STAGES-1:0]           vld_q;
  logic [DATA_W-1:0]           res_q [STAGES];
  logic [`EXECUTION_FLAGS-1:0] flg_q [STAGES];
  logic [TAG_W-1:0]            tag_q [STAGES];
  logic                        advance;
  logic                        load;

  assign advance = ~vld_q[STAGES-1] | ready_i;
  assign ready_o = advance;
  assign load    = valid_i & advance & ~flush_i;

  // Whole pipe moves in lockstep; flush only kills valid bits, data may stay stale.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        res_q[i] <= '0;
        flg_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else begin
      if (flush_i) begin
        vld_q <= '0;
      end else if (advance) begin
        vld_q[0] <= valid_i;
        for (int i = 1; i < STAGES; i++) vld_q[i] <= vld_q[i-1];
      end
      if (advance) begin
        if (load) begin
          res_q[0] <= alu_res;
          flg_q[0] <= alu_flags;
          tag_q[0] <= tag_i;
        end
        for (int i = 1; i < STAGES; i++) begin
          res_q[i] <= res_q[i-1];
          flg_q[i] <= flg_q[i-1];
          tag_q[i] <= tag_q[i-1];
        end
      end
    end
  end

  assign valid_o  = vld_q[STAGES-1];
  assign result_o = res_q[STAGES-1];
  assign flags_o  = flg_q[STAGES-1];
  assign tag_o    = tag_q[STAGES-1];

endmodule

// File: tb/tb_simple_alu_pipe.sv
// Directed self-checking bench for simple_alu_pipe (DATA_W=32, STAGES=2).
`ifndef SIMPLE_ALU_PIPE_DEFS
`define SIMPLE_ALU_PIPE_DEFS
`define SIZE_OPCODE_I   6
`define EXECUTION_FLAGS 6
`define ALU_NOP   6'd0
`define ALU_ADD   6'd1
`define ALU_ADDI  6'd2
`define ALU_ADDU  6'd3
`define ALU_ADDIU 6'd4
`define ALU_SUB   6'd5
`define ALU_SUBU  6'd6
`define ALU_MFHI  6'd7
`define ALU_MTHI  6'd8
`define ALU_MFLO  6'd9
`define ALU_MTLO  6'd10
`define ALU_AND_  6'd11
`define ALU_ANDI  6'd12
`define ALU_OR    6'd13
`define ALU_ORI   6'd14
`define ALU_XOR   6'd15
`define ALU_XORI  6'd16
`define ALU_NOR   6'd17
`define ALU_SLL   6'd18
`define ALU_SLLV  6'd19
`define ALU_SRL   6'd20
`define ALU_SRLV  6'd21
`define ALU_SRA   6'd22
`define ALU_SRAV  6'd23
`define ALU_SLT   6'd24
`define ALU_SLTI  6'd25
`define ALU_SLTU  6'd26
`define ALU_SLTIU 6'd27
`define ALU_LUI   6'd28
`endif

module tb_simple_alu_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush_i;
  logic        valid_i;
  logic        ready_o;
  logic [5:0]  opcode_i;
  logic [31:0] data1_i;
  logic [31:0] data2_i;
  logic [15:0] immd_i;
  logic [6:0]  tag_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] result_o;
  logic [5:0]  flags_o;
  logic [6:0]  tag_o;

  int cmp_count  = 0;
  int fail_count = 0;

  simple_alu_pipe #(.DATA_W(32), .IMM_W(16), .STAGES(2), .TAG_W(7)) dut (
    .clk      (clk),
    .reset    (reset),
    .flush_i  (flush_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .opcode_i (opcode_i),
    .data1_i  (data1_i),
    .data2_i  (data2_i),
    .immd_i   (immd_i),
    .tag_i    (tag_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .result_o (result_o),
    .flags_o  (flags_o),
    .tag_o    (tag_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    cmp_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] op, input logic [31:0] d1, input logic [31:0] d2,
                       input logic [15:0] imm, input logic [6:0] tg);
    valid_i  = 1'b1;
    opcode_i = op;
    data1_i  = d1;
    data2_i  = d2;
    immd_i   = imm;
    tag_i    = tg;
  endtask

  task automatic idle();
    valid_i = 1'b0;
  endtask

  // Issue one op into an empty pipe and check it surfaces exactly two edges later.
  task automatic run_single(input string name, input logic [5:0] op, input logic [31:0] d1,
                            input logic [31:0] d2, input logic [15:0] imm, input logic [6:0] tg,
                            input logic [31:0] exp_res, input logic [5:0] exp_flg);
    drive(op, d1, d2, imm, tg);
    tick();
    idle();
    check({name, "_lat1_valid"}, valid_o, 1'b0);
    tick();
    check({name, "_valid"}, valid_o, 1'b1);
    check({name, "_result"}, result_o, exp_res);
    check({name, "_flags"}, flags_o, exp_flg);
    check({name, "_tag"}, tag_o, tg);
    tick();
  endtask

  initial begin
    #20000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [5:0] ovf_flags;
`ifdef SIMPLE_ALU_OVF_TRAP_EN
    ovf_flags = 6'b100100;
`else
    ovf_flags = 6'b010100;
`endif
    reset = 1'b1; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    opcode_i = '0; data1_i = '0; data2_i = '0; immd_i = '0; tag_i = '0;
    #1;
    check("rst_valid",  valid_o,  1'b0);
    check("rst_result", result_o, 32'h0);
    check("rst_flags",  flags_o,  6'h0);
    check("rst_tag",    tag_o,    7'h0);
    check("rst_ready",  ready_o,  1'b1);
    tick();
    reset = 1'b0;
    tick();

    // reset asserted with two ops in flight
    drive(`ALU_ADD, 32'd1, 32'd2, 16'd0, 7'd8);
    tick();
    drive(`ALU_SUB, 32'd9, 32'd4, 16'd0, 7'd9);
    tick();
    idle();
    check("mid_pre_valid", valid_o, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_valid",  valid_o,  1'b0);
    check("mid_rst_result", result_o, 32'h0);
    check("mid_rst_tag",    tag_o,    7'h0);
    tick();
    reset = 1'b0;
    check("mid_rel_ready", ready_o, 1'b1);
    tick();
    check("mid_rel_valid1", valid_o, 1'b0);
    tick();
    check("mid_rel_valid2", valid_o, 1'b0);

    run_single("add_wrap", `ALU_ADD, 32'hFFFF_FFFF, 32'h1, 16'h0, 7'd5, 32'h0, 6'b010110);
    run_single("sub_borrow", `ALU_SUB, 32'd5, 32'd7, 16'h0, 7'd11, 32'hFFFF_FFFE, 6'b010110);
    run_single("add_ovf", `ALU_ADD, 32'h7FFF_FFFF, 32'h1, 16'h0, 7'd12, 32'h8000_0000, ovf_flags);
    run_single("nop", `ALU_NOP, 32'h1234, 32'h5678, 16'h0, 7'd13, 32'h0, 6'b000100);
    run_single("unlisted", 6'd63, 32'h1234, 32'h5678, 16'h0, 7'd14, 32'h0, 6'b000000);
    run_single("sltu", `ALU_SLTU, 32'hFFFF_FFFE, 32'h1, 16'h0, 7'd15, 32'h0, 6'b010100);
    run_single("srav", `ALU_SRAV, 32'h24, 32'h8000_0000, 16'h0, 7'd16, 32'hF800_0000, 6'b010100);
    run_single("ori_zext", `ALU_ORI, 32'h0, 32'h0, 16'h8001, 7'd17, 32'h0000_8001, 6'b010100);

    // back-to-back stream
    drive(`ALU_ADDI, 32'd10, 32'd0, 16'hFFFF, 7'd1);
    tick();
    drive(`ALU_SRA, 32'h8000_0000, 32'd0, 16'd4, 7'd2);
    tick();
    check("b2b_addi_valid", valid_o, 1'b1);
    check("b2b_addi_res", result_o, 32'd9);
    check("b2b_addi_tag", tag_o, 7'd1);
    drive(`ALU_SLT, 32'hFFFF_FFFE, 32'd1, 16'd0, 7'd3);
    tick();
    idle();
    check("b2b_sra_valid", valid_o, 1'b1);
    check("b2b_sra_res", result_o, 32'hF800_0000);
    check("b2b_sra_tag", tag_o, 7'd2);
    tick();
    check("b2b_slt_valid", valid_o, 1'b1);
    check("b2b_slt_res", result_o, 32'd1);
    check("b2b_slt_tag", tag_o, 7'd3);
    tick();
    check("b2b_drain", valid_o, 1'b0);

    // back-pressure with LUI at the output
    drive(`ALU_LUI, 32'd0, 32'd0, 16'h1234, 7'd3);
    tick();
    drive(`ALU_ORI, 32'hF0, 32'd0, 16'h000F, 7'd4);
    tick();
    ready_i = 1'b0;
    drive(`ALU_XOR, 32'h1, 32'h2, 16'h0, 7'd20);
    #1;
    check("stall_ready0", ready_o, 1'b0);
    check("stall_lui_res0", result_o, 32'h1234_0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_valid", valid_o, 1'b1);
      check("stall_res", result_o, 32'h1234_0000);
      check("stall_tag", tag_o, 7'd3);
      check("stall_ready", ready_o, 1'b0);
    end
    ready_i = 1'b1;
    idle();
    tick();
    check("stall_next_valid", valid_o, 1'b1);
    check("stall_next_res", result_o, 32'h0000_00FF);
    check("stall_next_tag", tag_o, 7'd4);
    tick();
    check("stall_no_accept", valid_o, 1'b0);

    // flush with two ops in flight, a new input, and a stall
    drive(`ALU_AND_, 32'hFF00_FF00, 32'h0F0F_0F0F, 16'h0, 7'd6);
    tick();
    drive(`ALU_XOR, 32'hFF, 32'h0F, 16'h0, 7'd7);
    tick();
    check("fl_pre_res", result_o, 32'h0F00_0F00);
    check("fl_pre_valid", valid_o, 1'b1);
    ready_i = 1'b0;
    flush_i = 1'b1;
    drive(`ALU_OR, 32'h1, 32'h2, 16'h0, 7'd10);
    tick();
    check("fl_valid0", valid_o, 1'b0);
    flush_i = 1'b0;
    ready_i = 1'b1;
    idle();
    tick();
    check("fl_valid1", valid_o, 1'b0);
    tick();
    check("fl_valid2", valid_o, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
    $finish;
  end

endmodule
